// File: rtl/fp_sign_pkg.sv
// Shared types and the sign-resolution rule for the vector FP add/sub result path.
// Pure package: no latency, no flow control.
// Used by fp_sign_resolve, sign_ctx_fifo and the scalar FPU checker.
//
// CTX_TAG_W is the tag width stored in every context entry. It is the widest
// tag any instance may use. Narrower instances zero-extend on write and
// truncate on read.
package fp_sign_pkg;

    localparam int CTX_TAG_W = 16;

    typedef struct packed {
        logic                 sa;       // sign of A
        logic                 sb_e;     // effective sign of B (op inversion applied)
        logic                 swap;     // B was the larger-exponent operand
        logic                 eff_sub;  // signs differ -> magnitudes are subtracted
        logic [CTX_TAG_W-1:0] tag;
    } sign_ctx_t;

    // Rules for the result sign:
    // - Same-sign add: the result keeps A's sign.
    // - Exact cancellation: the result is +0, except under round-down, where it is -0.
    // - Otherwise: the sign of the larger operand is used, flipped if the mantissa
    //   subtraction borrowed. A borrow means the operand that exponent compare
    //   chose as larger was in fact smaller.
    function automatic logic resolve_sign(input sign_ctx_t ctx,
                                          input logic      mag_zero,
                                          input logic      mag_neg,
                                          input logic      rdn);
        logic s_big;
        logic unused_tag;
        unused_tag = ^ctx.tag;
        s_big      = ctx.swap ? ctx.sb_e : ctx.sa;
        if (!ctx.eff_sub) begin
            return ctx.sa;
        end else if (mag_zero) begin
            return rdn;
        end else begin
            return s_big ^ mag_neg;
        end
    endfunction

endpackage

// File: rtl/sign_ctx_fifo.sv
// DEPTH-entry synchronous FIFO of sign_ctx_t contexts.
// Latency: a write is readable from the cycle after the write (no bypass).
// Backpressure: a write while full and a read while empty are ignored. The caller gates both.
//
// Ports: clk_i, rst_ni (async active-low), wr_en_i/wr_dat_i (push),
//        rd_en_i/rd_dat_o (pop, head shown combinationally), full_o, empty_o, count_o.
module sign_ctx_fifo
    import fp_sign_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  sign_ctx_t                  wr_dat_i,
    input  logic                       rd_en_i,
    output sign_ctx_t                  rd_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    sign_ctx_t     mem_q [DEPTH];

    logic do_wr;
    logic do_rd;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // Full is judged on the registered count. Because of that, a pop in the same
    // cycle never makes room for a push.
    assign do_wr = wr_en_i & ~full_o;
    assign do_rd = rd_en_i & ~empty_o;

    assign rd_dat_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/fp_sign_resolve.sv
// Result-side sign resolution for the FP add/sub path: stores the issue-side sign context and resolves the sign from the mantissa flags.
// Latency: push at t, mantissa flags accepted at t+1, registered result valid at t+2. Throughput is one result per cycle.
// Backpressure: in_ready_o drops when the context FIFO is full. mag_ready_o drops when the FIFO is empty or the output is stalled.
//
// Ports: clk_i, rst_ni (async active-low)
//        issue side : in_valid_i/in_ready_o, sa_i, sb_i, swap_i, sub_i, tag_i
//        mantissa   : mag_valid_i/mag_ready_o, mag_zero_i, mag_neg_i, rdn_i
//        result     : out_valid_o/out_ready_i, sign_o, eff_sub_o, tag_o
// Optional: define FP_SIGN_RESOLVE_ERR_EN to add err_o. err_o is a sticky
// context-underflow flag, cleared only by reset.
// TAG_W must not exceed fp_sign_pkg::CTX_TAG_W.
module fp_sign_resolve
    import fp_sign_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             sa_i,
    input  logic             sb_i,
    input  logic             swap_i,
    input  logic             sub_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             mag_valid_i,
    output logic             mag_ready_o,
    input  logic             mag_zero_i,
    input  logic             mag_neg_i,
    input  logic             rdn_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             sign_o,
    output logic             eff_sub_o,
`ifdef FP_SIGN_RESOLVE_ERR_EN
    output logic             err_o,
`endif
    output logic [TAG_W-1:0] tag_o
);

    sign_ctx_t              push_ctx;
    sign_ctx_t              head_ctx;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   push;
    logic                   pop;
    logic                   unused_ctx;

    logic             out_valid_q, out_valid_d;
    logic             sign_q,      sign_d;
    logic             eff_sub_q,   eff_sub_d;
    logic [TAG_W-1:0] tag_q,       tag_d;

    // Fold the op inversion into B's sign at issue. Eff_sub is then a single
    // compare of two signs.
    always_comb begin
        push_ctx         = '0;
        push_ctx.sa      = sa_i;
        push_ctx.sb_e    = sb_i ^ sub_i;
        push_ctx.swap    = swap_i;
        push_ctx.eff_sub = sa_i ^ (sb_i ^ sub_i);
        push_ctx.tag     = CTX_TAG_W'(tag_i);
    end

    assign in_ready_o  = ~fifo_full;
    assign push        = in_valid_i & in_ready_o;
    // A result may be consumed only if the output slot is free or drains this cycle.
    assign mag_ready_o = ~fifo_empty & (~out_valid_q | out_ready_i);
    assign pop         = mag_valid_i & mag_ready_o;

    sign_ctx_fifo #(
        .DEPTH (DEPTH)
    ) u_ctx_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_en_i  (push),
        .wr_dat_i (push_ctx),
        .rd_en_i  (pop),
        .rd_dat_o (head_ctx),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // The occupancy count is exported only for debug. The upper tag bits exist
    // only when TAG_W is narrower than the storage width.
    assign unused_ctx = ^{fifo_count, head_ctx.tag};

    always_comb begin
        out_valid_d = out_valid_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        tag_d       = tag_q;
        if (pop) begin
            out_valid_d = 1'b1;
            sign_d      = resolve_sign(head_ctx, mag_zero_i, mag_neg_i, rdn_i);
            eff_sub_d   = head_ctx.eff_sub;
            tag_d       = head_ctx.tag[TAG_W-1:0];
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign sign_o      = sign_q;
    assign eff_sub_o   = eff_sub_q;
    assign tag_o       = tag_q;

`ifdef FP_SIGN_RESOLVE_ERR_EN
    // Flags arriving with no stored context mean the mantissa path and the
    // issue side have lost step. The flag latches until reset.
    logic err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (mag_valid_i & fifo_empty) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`endif

endmodule
